// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared FSM encoding, default LFSR taps and LFSR step function
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FIRE,
      ST_SAMPLE,
      ST_DONE
   } puf_state_t;

   localparam logic [63:0] DEFAULT_TAPS = 64'hD800_0000_0000_0000;

   // Operates on up to 64 bits; bits at or above width are forced to zero.
   function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                             input logic [63:0] taps,
                                             input int          width);
      logic [63:0] mask;
      logic        fb;
      mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      fb   = ^(state & taps & mask);
      return ((state << 1) | {63'd0, fb}) & mask;
   endfunction

endpackage

// File: rtl/puf_lfsr.sv
// rtl/puf_lfsr.sv - challenge LFSR, loadable from the host seed, advanced per challenge
module puf_lfsr
   import puf_pkg::*;
#(
   parameter int                STAGES = 64,
   parameter logic [STAGES-1:0] TAPS   = STAGES'(DEFAULT_TAPS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [STAGES-1:0] i_seed,
   input  logic              i_adv,
   output logic [STAGES-1:0] o_state
);

   logic [STAGES-1:0] r_state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= '0;
      end else if (i_load) begin
         r_state <= i_seed;
      end else if (i_adv) begin
         r_state <= STAGES'(lfsr_next(64'(r_state), 64'(TAPS), STAGES));
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - arbiter-PUF race sequencer with per-challenge majority vote
module puf_challenge_sequencer
   import puf_pkg::*;
#(
   parameter int                STAGES     = 64,
   parameter int                RESP_BITS  = 32,
   parameter int                REPEATS    = 5,
   parameter int                SETTLE_CYC = 8,
   parameter logic [STAGES-1:0] TAPS       = STAGES'(DEFAULT_TAPS)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [STAGES-1:0]    i_seed,
   output logic                 o_busy,
   output logic [STAGES-1:0]    o_challenge,
   output logic                 o_launch,
   output logic                 o_arbiter_clr,
   input  logic                 i_arbiter_out,
   output logic [RESP_BITS-1:0] o_response,
   output logic                 o_valid,
   output logic                 o_error
);

   localparam int VOTE_W = $clog2(REPEATS + 1);
   localparam int REP_W  = (REPEATS > 1) ? $clog2(REPEATS) : 1;
   localparam int BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
   localparam int CNT_W  = $clog2(SETTLE_CYC + 3);

   if ((REPEATS % 2) == 0 || REPEATS < 1 || SETTLE_CYC == 0) begin : g_bad_params
      $error("puf_challenge_sequencer: REPEATS must be odd and SETTLE_CYC nonzero");
   end

   puf_state_t           r_state, w_next;
   logic [CNT_W-1:0]     r_cnt;
   logic [REP_W-1:0]     r_rep;
   logic [VOTE_W-1:0]    r_votes;
   logic [BIT_W-1:0]     r_bit_idx;
   logic [RESP_BITS-1:0] r_shadow, r_response;
   logic                 r_valid, r_error;
   logic [1:0]           r_sync;

   logic              w_start_ok, w_load_last, w_fire_last, w_last_rep, w_last_bit;
   logic              w_decision, w_lfsr_load, w_lfsr_adv;
   logic              w_launch, w_clr, w_busy;
   logic [VOTE_W-1:0] w_votes_incl;

   assign w_start_ok   = i_start && (i_seed != '0);
   assign w_load_last  = (r_cnt == CNT_W'(SETTLE_CYC - 1));
   assign w_fire_last  = (r_cnt == CNT_W'(SETTLE_CYC + 1));
   assign w_last_rep   = (r_rep == REP_W'(REPEATS - 1));
   assign w_last_bit   = (r_bit_idx == BIT_W'(RESP_BITS - 1));
   assign w_votes_incl = r_votes + VOTE_W'(r_sync[1]);
   assign w_decision   = (w_votes_incl > VOTE_W'(REPEATS / 2));
   assign w_lfsr_load  = (r_state == ST_IDLE) && w_start_ok;
   assign w_lfsr_adv   = (r_state == ST_SAMPLE) && w_last_rep;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_start_ok)  w_next = ST_LOAD;
         ST_LOAD:   if (w_load_last) w_next = ST_FIRE;
         ST_FIRE:   if (w_fire_last) w_next = ST_SAMPLE;
         ST_SAMPLE: w_next = (w_last_rep && w_last_bit) ? ST_DONE : ST_LOAD;
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Launch spans FIRE and SAMPLE so the edge is still held while the vote is taken.
   always_comb begin
      w_launch = 1'b0;
      w_clr    = 1'b0;
      w_busy   = 1'b1;
      case (r_state)
         ST_IDLE:   w_busy   = 1'b0;
         ST_LOAD:   w_clr    = 1'b1;
         ST_FIRE:   w_launch = 1'b1;
         ST_SAMPLE: w_launch = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_rep      <= '0;
         r_votes    <= '0;
         r_bit_idx  <= '0;
         r_shadow   <= '0;
         r_response <= '0;
         r_valid    <= 1'b0;
         r_error    <= 1'b0;
         r_sync     <= '0;
      end else begin
         r_sync  <= {r_sync[0], i_arbiter_out};
         r_valid <= (r_state == ST_DONE);
         r_error <= (r_state == ST_IDLE) && i_start && (i_seed == '0);
         if ((r_state == ST_LOAD || r_state == ST_FIRE) && (w_next == r_state))
            r_cnt <= r_cnt + CNT_W'(1);
         else
            r_cnt <= '0;
         if (w_lfsr_load) begin
            r_rep     <= '0;
            r_votes   <= '0;
            r_bit_idx <= '0;
         end
         if (r_state == ST_SAMPLE) begin
            if (!w_last_rep) begin
               r_rep   <= r_rep + REP_W'(1);
               r_votes <= w_votes_incl;
            end else begin
               r_shadow[r_bit_idx] <= w_decision;
               r_rep               <= '0;
               r_votes             <= '0;
               if (!w_last_bit) r_bit_idx <= r_bit_idx + BIT_W'(1);
            end
         end
         if (r_state == ST_DONE) r_response <= r_shadow;
      end
   end

   puf_lfsr #(
      .STAGES (STAGES),
      .TAPS   (TAPS)
   ) u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_lfsr_load),
      .i_seed  (i_seed),
      .i_adv   (w_lfsr_adv),
      .o_state (o_challenge)
   );

   assign o_busy        = w_busy;
   assign o_launch      = w_launch;
   assign o_arbiter_clr = w_clr;
   assign o_response    = r_response;
   assign o_valid       = r_valid;
   assign o_error       = r_error;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - directed self-checking bench for puf_challenge_sequencer
module tb_puf_challenge_sequencer;

   localparam int SETTLE  = 8;
   localparam int REPS    = 5;
   localparam int LATENCY = 3041;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] seed = 64'd0;
   logic        busy, launch, clr, valid, err;
   logic [63:0] challenge;
   logic [31:0] response;
   logic        arb_out = 1'b0;

   int total = 0;
   int bad   = 0;

   logic arb_mode  = 1'b0;
   logic arb_const = 1'b0;
   logic chk_chal  = 1'b0;
   logic prev_clr  = 1'b0;
   int   clr_run   = 0;
   int   races     = 0;
   int   lat;
   int   nvalid;
   int   nlaunch;

   puf_challenge_sequencer dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_seed        (seed),
      .o_busy        (busy),
      .o_challenge   (challenge),
      .o_launch      (launch),
      .o_arbiter_clr (clr),
      .i_arbiter_out (arb_out),
      .o_response    (response),
      .o_valid       (valid),
      .o_error       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock; checks and the arbiter model run at the falling edge.
   task automatic tick();
      int b;
      int r;
      @(posedge clk);
      @(negedge clk);
      if (!rst_n) begin
         prev_clr = 1'b0;
         clr_run  = 0;
         races    = 0;
         return;
      end
      chk("no_overlap", 64'(launch & clr), 64'd0);
      if (clr) begin
         clr_run++;
      end else if (prev_clr) begin
         chk("clr_len", 64'(clr_run), 64'(SETTLE));
         clr_run = 0;
      end
      if (!busy) races = 0;
      if (clr && !prev_clr) begin
         b = races / REPS;
         r = races % REPS;
         if (arb_mode) arb_out = ((b % 2) == 0) ? (r < 3) : (r < 2);
         else          arb_out = arb_const;
         if (chk_chal && r == 0) chk("challenge", challenge, 64'd1 << b);
         races++;
      end
      prev_clr = clr;
   endtask

   task automatic run(input logic [63:0] s, input int repulse_at, input int max_cyc,
                      output int first_valid, output int valid_count);
      first_valid = -1;
      valid_count = 0;
      seed  = s;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n <= max_cyc; n++) begin
         if (n == repulse_at) start = 1'b1;
         tick();
         start = 1'b0;
         if (valid) begin
            valid_count++;
            if (first_valid < 0) first_valid = n;
         end
      end
   endtask

   initial begin
      #12;
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_chal",  challenge,  64'd0);
      chk("rst_resp",  64'(response), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_clr",   64'(clr),   64'd0);
      chk("rst_launch", 64'(launch), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Seed 1, arbiter always 1
      arb_mode  = 1'b0;
      arb_const = 1'b1;
      chk_chal  = 1'b1;
      run(64'd1, 0, LATENCY + 20, lat, nvalid);
      chk_chal  = 1'b0;
      chk("ones_latency", 64'(lat), 64'(LATENCY));
      chk("ones_nvalid",  64'(nvalid), 64'd1);
      chk("ones_resp",    64'(response), 64'hFFFF_FFFF);
      chk("ones_busy",    64'(busy), 64'd0);

      // Marginal majorities
      arb_mode = 1'b1;
      run(64'h1234_5678_9ABC_DEF1, 0, LATENCY + 5, lat, nvalid);
      chk("vote_latency", 64'(lat), 64'(LATENCY));
      chk("vote_resp",    64'(response), 64'h5555_5555);

      // Reset mid-FIRE
      seed  = 64'hA5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 40 && !launch; n++) tick();
      chk("fire_reached", 64'(launch), 64'd1);
      tick();
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_launch", 64'(launch), 64'd0);
      chk("arst_busy",   64'(busy),   64'd0);
      chk("arst_valid",  64'(valid),  64'd0);
      chk("arst_clr",    64'(clr),    64'd0);
      chk("arst_resp",   64'(response), 64'd0);
      chk("arst_chal",   challenge,   64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Zero seed
      seed  = 64'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("err_pulse", 64'(err),  64'd1);
      chk("err_busy",  64'(busy), 64'd0);
      nlaunch = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (launch || busy || err) nlaunch++;
      end
      chk("err_quiet", 64'(nlaunch), 64'd0);

      // Start re-pulsed while busy is ignored
      run(64'h0F0F_0000_0000_0001, 100, LATENCY + 200, lat, nvalid);
      chk("repulse_latency", 64'(lat), 64'(LATENCY));
      chk("repulse_nvalid",  64'(nvalid), 64'd1);
      chk("repulse_resp",    64'(response), 64'h5555_5555);

      // Reset at bit 10, then a clean run
      arb_mode  = 1'b0;
      arb_const = 1'b1;
      seed  = 64'h77;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 2000 && races <= 10 * REPS; n++) tick();
      for (int n = 0; n < 40 && !launch; n++) tick();
      chk("bit10_reached", 64'(races), 64'(10 * REPS + 1));
      #1;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      nvalid = 0;
      for (int n = 0; n < LATENCY; n++) begin
         tick();
         if (valid || busy) nvalid++;
      end
      chk("abandon_quiet", 64'(nvalid), 64'd0);
      chk("abandon_resp",  64'(response), 64'd0);
      run(64'h77, 0, LATENCY + 5, lat, nvalid);
      chk("clean_latency", 64'(lat), 64'(LATENCY));
      chk("clean_nvalid",  64'(nvalid), 64'd1);
      chk("clean_resp",    64'(response), 64'hFFFF_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
